// File: rtl/icache_if.sv
// rtl/icache_if.sv - datapath and memory-controller signals of the instruction cache
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-frame instruction cache, blocking refill
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache #(
    parameter int NUM_FRAMES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    icache_if.slave     cif
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX   = $clog2(NUM_FRAMES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state, next_state;

    logic [NUM_FRAMES-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_FRAMES];
    logic [31:0]           data_q [NUM_FRAMES];
    logic [29:0]           fetch_word;

    logic [IDX-1:0]   req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX-1:0]   fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             miss_start;
    logic             fill_done;

    // Byte offset carries no information for word-aligned fetches.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^cif.imemaddr[1:0];

    assign req_idx  = cif.imemaddr[IDX+1:2];
    assign req_tag  = cif.imemaddr[31:IDX+2];
    assign fill_idx = fetch_word[IDX-1:0];
    assign fill_tag = fetch_word[29:IDX];

    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign miss_start = (state == IDLE) && cif.imemREN && !hit;
    assign fill_done  = (state == FETCH) && !cif.iwait;

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (miss_start) next_state = FETCH;
            FETCH:   if (fill_done)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cif.ihit     = 1'b0;
        cif.imemload = 32'h0;
        cif.iREN     = 1'b0;
        cif.iaddr    = 32'h0;
        case (state)
            IDLE: begin
                cif.ihit = cif.imemREN && hit;
                if (cif.imemREN && hit) begin
                    cif.imemload = data_q[req_idx];
                end
            end
            FETCH: begin
                cif.iREN  = 1'b1;
                cif.iaddr = {fetch_word, 2'b00};
            end
            default: ;
        endcase
    end

    // The miss address is captured once; later datapath changes cannot redirect the fill.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            fetch_word <= 30'h0;
        end else if (miss_start) begin
            fetch_word <= cif.imemaddr[31:2];
        end
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_FRAMES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= 32'h0;
            end
        end else if (fill_done) begin
            valid_q[fill_idx] <= 1'b1;
            tag_q[fill_idx]   <= fill_tag;
            data_q[fill_idx]  <= cif.iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (cif.ihit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed and randomized checks of icache against a behavioural model
module tb_icache;
    localparam int NF = 16;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    icache_if bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache #(.NUM_FRAMES(NF)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .cif(bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: each frame remembers which word address it holds; a busy flag marks an outstanding fill.
    bit          m_valid [NF];
    logic [31:0] m_addr  [NF];
    logic [31:0] m_data  [NF];
    bit          m_busy;
    logic [31:0] m_fa;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    always @(negedge CLK) begin
        int  idx;
        int  fidx;
        bit  hit;
        bit  e_hit;
        if (!nRST) begin
            check("rst_ihit", 32'(bus.ihit), 32'h0);
            check("rst_imemload", bus.imemload, 32'h0);
            check("rst_iREN", 32'(bus.iREN), 32'h0);
            check("rst_iaddr", bus.iaddr, 32'h0);
            for (int i = 0; i < NF; i++) begin
                m_valid[i] = 1'b0;
                m_addr[i]  = 32'h0;
                m_data[i]  = 32'h0;
            end
            m_busy   = 1'b0;
            m_fa     = 32'h0;
            m_hits   = 32'h0;
            m_misses = 32'h0;
        end else begin
            idx = int'((bus.imemaddr >> 2) % NF);
            hit = m_valid[idx] && (m_addr[idx][31:2] == bus.imemaddr[31:2]);
            e_hit = !m_busy && bus.imemREN && hit;
            check("ihit", 32'(bus.ihit), 32'(e_hit));
            check("imemload", bus.imemload, e_hit ? m_data[idx] : 32'h0);
            check("iREN", 32'(bus.iREN), 32'(m_busy));
            check("iaddr", bus.iaddr, m_busy ? {m_fa[31:2], 2'b00} : 32'h0);
`ifdef ICACHE_STATS_EN
            check("hit_count", hit_count, m_hits);
            check("miss_count", miss_count, m_misses);
`endif
            if (e_hit) m_hits = m_hits + 32'd1;
            if (!m_busy && bus.imemREN && !hit) begin
                m_busy   = 1'b1;
                m_fa     = bus.imemaddr;
                m_misses = m_misses + 32'd1;
            end else if (m_busy && !bus.iwait) begin
                fidx          = int'((m_fa >> 2) % NF);
                m_valid[fidx] = 1'b1;
                m_addr[fidx]  = m_fa;
                m_data[fidx]  = bus.iload;
                m_busy        = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic drive(input logic ren, input logic [31:0] a, input logic w, input logic [31:0] ld);
        bus.imemREN  = ren;
        bus.imemaddr = a;
        bus.iwait    = w;
        bus.iload    = ld;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 32'h0);
        sample();
        check("reset_iREN", 32'(bus.iREN), 32'h0);
        check("reset_iaddr", bus.iaddr, 32'h0);
        cyc();
        cyc();
        nRST = 1'b1;

        // Cold miss: three busy cycles then data.
        drive(1'b1, 32'h0, 1'b1, 32'h8C010004);
        sample();
        check("cold_miss_ihit", 32'(bus.ihit), 32'h0);
        check("cold_miss_iREN", 32'(bus.iREN), 32'h0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            bus.iwait = (k < 3);
            sample();
            check("cold_fetch_iREN", 32'(bus.iREN), 32'h1);
            check("cold_fetch_iaddr", bus.iaddr, 32'h0);
            cyc();
        end
        bus.iwait = 1'b1;
        sample();
        check("cold_hit_ihit", 32'(bus.ihit), 32'h1);
        check("cold_hit_load", bus.imemload, 32'h8C010004);
        cyc();
        sample();
        check("rehit_ihit", 32'(bus.ihit), 32'h1);
        check("rehit_iREN", 32'(bus.iREN), 32'h0);

        // Conflict on index 0.
        cyc();
        drive(1'b1, 32'h40, 1'b1, 32'h11112222);
        sample();
        check("conflict_ihit", 32'(bus.ihit), 32'h0);
        cyc();
        bus.iwait = 1'b0;
        sample();
        check("conflict_iaddr", bus.iaddr, 32'h40);
        cyc();
        sample();
        check("conflict_fill_load", bus.imemload, 32'h11112222);
        cyc();
        drive(1'b1, 32'h0, 1'b1, 32'h0);
        sample();
        check("evicted_ihit", 32'(bus.ihit), 32'h0);
        cyc();
        bus.iwait = 1'b0;
        bus.iload = 32'h8C010004;
        sample();
        check("evicted_iaddr", bus.iaddr, 32'h0);
        cyc();

        // Fill survives the datapath walking away.
        drive(1'b1, 32'h8, 1'b1, 32'h0);
        sample();
        check("abort_miss_ihit", 32'(bus.ihit), 32'h0);
        cyc();
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h10;
        sample();
        check("abort_iaddr", bus.iaddr, 32'h8);
        cyc();
        sample();
        check("abort_still_iREN", 32'(bus.iREN), 32'h1);
        cyc();
        bus.iwait = 1'b0;
        bus.iload = 32'hCAFEBABE;
        sample();
        cyc();
        sample();
        check("idle_no_req_iREN", 32'(bus.iREN), 32'h0);
        cyc();
        drive(1'b1, 32'h8, 1'b1, 32'h0);
        sample();
        check("abort_later_hit", 32'(bus.ihit), 32'h1);
        check("abort_later_load", bus.imemload, 32'hCAFEBABE);

        // Reset in the middle of a fill.
        cyc();
        drive(1'b1, 32'h80, 1'b1, 32'h0);
        sample();
        cyc();
        sample();
        check("midfetch_iREN", 32'(bus.iREN), 32'h1);
        cyc();
        nRST = 1'b0;
        #1;
        check("async_rst_iREN", 32'(bus.iREN), 32'h0);
        check("async_rst_iaddr", bus.iaddr, 32'h0);
        cyc();
        nRST = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 32'h0);
        sample();
        check("post_rst_miss", 32'(bus.ihit), 32'h0);
        cyc();
        sample();
        check("post_rst_iaddr", bus.iaddr, 32'h0);

        // Counter scenario: one cold miss on 0x04 then three hit cycles.
        cyc();
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        drive(1'b1, 32'h4, 1'b0, 32'h12345678);
        sample();
        cyc();
        sample();
        cyc();
        for (int k = 0; k < 3; k++) begin
            sample();
            check("stats_hit_cycle", 32'(bus.ihit), 32'h1);
            cyc();
        end
        bus.imemREN = 1'b0;
        sample();
`ifdef ICACHE_STATS_EN
        check("stats_hit_count", hit_count, 32'd3);
        check("stats_miss_count", miss_count, 32'd1);
`endif

        // Randomized traffic over a small address pool to force conflicts and refills.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            nRST         = ($urandom_range(0, 399) != 0);
            bus.imemREN  = ($urandom_range(0, 9) < 8);
            bus.imemaddr = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) bus.imemaddr = bus.imemaddr | 32'h80000000;
            bus.iwait    = $urandom_range(0, 1) != 0;
            bus.iload    = $urandom;
        end
        cyc();
        nRST = 1'b1;
        bus.imemREN = 1'b0;
        bus.iwait   = 1'b0;
        cyc();
        cyc();
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
